// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter owning a single shared WIDTH-bit register.
// The granted requester writes its lane every cycle, up to MAX_HOLD writes per grant.
module rr_reg_arbiter #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX_HOLD = 3,
    localparam int unsigned OwnW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      q,
    output logic                  upd,
    output logic [OwnW-1:0]       owner
);

    localparam int unsigned CntW = $clog2(MAX_HOLD + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_HOLD);
    localparam logic [OwnW-1:0] LastIdx = OwnW'(NREQ - 1);

    typedef enum logic {StIdle, StOwn} state_e;

    state_e            state_q;
    logic [NREQ-1:0]   gnt_q;
    logic [WIDTH-1:0]  q_q;
    logic              upd_q;
    logic [OwnW-1:0]   owner_q;
    logic [OwnW-1:0]   ptr_q;
    logic [CntW-1:0]   cnt_q;

    logic [WIDTH-1:0]  lane [NREQ];
    logic              win_vld;
    logic [OwnW-1:0]   win;
    logic [NREQ-1:0]   gnt_win;
    logic [OwnW-1:0]   ptr_next;
    logic [CntW-1:0]   cnt_inc;
    int unsigned       idx;

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        assign lane[i] = wdata[i*WIDTH +: WIDTH];
    end

    // Wrapping priority search starting at the round-robin pointer.
    always_comb begin
        win_vld = 1'b0;
        win     = '0;
        gnt_win = '0;
        idx     = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = (32'(ptr_q) + i) % NREQ;
            if (!win_vld && req[idx[OwnW-1:0]]) begin
                win_vld = 1'b1;
                win     = idx[OwnW-1:0];
            end
        end
        gnt_win[win] = 1'b1;
    end

    assign ptr_next = (owner_q == LastIdx) ? '0 : owner_q + 1'b1;
    assign cnt_inc  = cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            q_q     <= '0;
            upd_q   <= 1'b0;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    upd_q <= 1'b0;
                    if (win_vld) begin
                        gnt_q   <= gnt_win;
                        owner_q <= win;
                        cnt_q   <= '0;
                        state_q <= StOwn;
                    end
                end
                StOwn: begin
                    if (req[owner_q]) begin
                        q_q   <= lane[owner_q];
                        upd_q <= 1'b1;
                        cnt_q <= cnt_inc;
                    end else begin
                        upd_q <= 1'b0;
                    end
                    // Release when the owner lets go or has used its last write.
                    if (!req[owner_q] || cnt_inc == MaxCnt) begin
                        gnt_q   <= '0;
                        state_q <= StIdle;
                        ptr_q   <= ptr_next;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign gnt   = gnt_q;
    assign q     = q_q;
    assign upd   = upd_q;
    assign owner = owner_q;

endmodule
